// File: rtl/filter_pkg.sv
// Shared definitions for the filter tap sequencer: storage geometry, FSM
// state encoding and the tap-count clamp.
package filter_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Tap count is kept in 1..DEPTH so the READ loop always terminates.
  function automatic logic [ADDR_W:0] clamp_taps(input logic [ADDR_W:0] c);
    if (c == '0)
      return (ADDR_W+1)'(1);
    else if (c > DEPTH_V)
      return DEPTH_V;
    else
      return c;
  endfunction

endpackage

// File: rtl/filter_tap_rdpipe.sv
// One-cycle read-return pipeline: carries tap metadata alongside the storage
// read so it lines up with mem_rddata, and substitutes zero for padded taps.
module filter_tap_rdpipe
  import filter_pkg::*;
(
  input  logic              clk,
  input  logic              rstb,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_idx,
  input  logic              iss_first,
  input  logic              iss_last,
  input  logic              iss_rden,
  input  logic [DATA_W-1:0] mem_rddata,
  output logic              tap_valid,
  output logic [ADDR_W-1:0] tap_idx,
  output logic [DATA_W-1:0] tap_data,
  output logic              tap_first,
  output logic              tap_last
);

  logic rd_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rstb) begin
      tap_valid <= 1'b0;
      tap_idx   <= '0;
      tap_first <= 1'b0;
      tap_last  <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      tap_valid <= iss_valid;
      tap_idx   <= iss_valid ? iss_idx : '0;
      tap_first <= iss_valid && iss_first;
      tap_last  <= iss_valid && iss_last;
      rd_q      <= iss_valid && iss_rden;
    end
  end

  // NOTE: storage data is already registered inside the memory, so the mux is
  // applied after it rather than adding a second cycle of latency.
  assign tap_data = rd_q ? mem_rddata : '0;

endmodule

// File: rtl/filter_tap_sequencer.sv
// Controller for filter_storage: writes each accepted sample at a circular
// pointer, then reads back the newest ntaps samples newest-first as a tap stream.
module filter_tap_sequencer
  import filter_pkg::*;
(
  input  logic              clk,
  input  logic              rstb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W:0]   cfg_taps,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_wrptr,
  output logic [DATA_W-1:0] mem_wrdata,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_rdptr,
  input  logic [DATA_W-1:0] mem_rddata,
  output logic              tap_valid,
  output logic [ADDR_W-1:0] tap_idx,
  output logic [DATA_W-1:0] tap_data,
  output logic              tap_first,
  output logic              tap_last,
  output logic              busy
);

  state_t            state;
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W:0]   fill;
  logic [ADDR_W:0]   ntaps;
  logic [ADDR_W:0]   k_ext;
  logic [ADDR_W:0]   fill_next;
  logic              last_k;

  assign k_ext     = {1'b0, k};
  assign last_k    = (k_ext == ntaps - 1'b1);
  assign fill_next = (fill == DEPTH_V) ? fill : fill + 1'b1;

  assign in_ready = (state == IDLE) && !rstb;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rstb) begin
      state      <= IDLE;
      wp         <= '0;
      k          <= '0;
      fill       <= '0;
      ntaps      <= '0;
      mem_wren   <= 1'b0;
      mem_wrptr  <= '0;
      mem_wrdata <= '0;
      mem_rden   <= 1'b0;
      mem_rdptr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ntaps      <= clamp_taps(cfg_taps);
            mem_wren   <= 1'b1;
            mem_wrptr  <= wp;
            mem_wrdata <= in_data;
            state      <= WRITE;
          end
        end
        WRITE: begin
          mem_wren  <= 1'b0;
          fill      <= fill_next;
          k         <= '0;
          mem_rden  <= (fill_next != '0);
          mem_rdptr <= wp;
          state     <= READ;
        end
        READ: begin
          if (last_k) begin
            mem_rden <= 1'b0;
            state    <= DRAIN;
          end else begin
            // Taps beyond the written history are padded: no read is issued.
            k         <= k + 1'b1;
            mem_rden  <= (k_ext + 1'b1 < fill);
            mem_rdptr <= wp - k - 1'b1;
          end
        end
        DRAIN: begin
          wp    <= wp + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  filter_tap_rdpipe u_rdpipe (
    .clk        (clk),
    .rstb       (rstb),
    .iss_valid  (state == READ),
    .iss_idx    (k),
    .iss_first  (k == '0),
    .iss_last   (last_k),
    .iss_rden   (mem_rden),
    .mem_rddata (mem_rddata),
    .tap_valid  (tap_valid),
    .tap_idx    (tap_idx),
    .tap_data   (tap_data),
    .tap_first  (tap_first),
    .tap_last   (tap_last)
  );

endmodule
